// File: rtl/rv_pkg.sv
// rv_pkg: register-file widths and the write-back queue entry type.
package rv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fwd_lookup.sv
// wb_fwd_lookup: finds the youngest pending write to addr_i among the queued entries.
module wb_fwd_lookup
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  wb_entry_t             entries_i [DEPTH],
    input  logic [AW-1:0]         head_i,
    input  logic [CW-1:0]         count_i,
    input  logic [REG_ADDR_W-1:0] addr_i,
    output logic                  hit_o,
    output logic [XLEN-1:0]       data_o
);
    logic [AW-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        // Walk oldest to youngest so the youngest match overwrites earlier ones.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + AW'(i);
            if (CW'(i) < count_i && addr_i != '0 && entries_i[idx].valid && entries_i[idx].rd == addr_i) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end
endmodule

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order buffer of ALU/load register writes, drained one per
// cycle into the register file write port, with two forwarding lookup ports.
module rf_writeback_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = rv_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [REG_ADDR_W-1:0]    alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    input  logic [REG_ADDR_W-1:0]    ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     in_ready,
    output logic                     rf_we,
    output logic [REG_ADDR_W-1:0]    rf_a3,
    output logic [XLEN-1:0]          rf_wd,
    input  logic [REG_ADDR_W-1:0]    fwd_a1,
    input  logic [REG_ADDR_W-1:0]    fwd_a2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [XLEN-1:0]          fwd_data1,
    output logic [XLEN-1:0]          fwd_data2,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t     entries_q [DEPTH];
    wb_entry_t     entries_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ld, push_alu, pop;

    // Two free slots are required so a same-cycle ld+alu pair always fits.
    assign in_ready = count_q <= CW'(DEPTH - 2);
    assign push_ld  = ld_valid && in_ready && ld_rd != '0;
    assign push_alu = alu_valid && in_ready && alu_rd != '0;
    assign pop      = count_q != '0;
    assign rf_we    = pop;
    assign rf_a3    = pop ? entries_q[head_q].rd : '0;
    assign rf_wd    = pop ? entries_q[head_q].data : '0;
    assign pending  = count_q;

    always_comb begin
        entries_d = entries_q;
        if (pop) entries_d[head_q].valid = 1'b0;
        if (push_ld) entries_d[tail_q] = '{valid: 1'b1, rd: ld_rd, data: ld_data};
        if (push_alu) entries_d[tail_q + AW'(push_ld)] = '{valid: 1'b1, rd: alu_rd, data: alu_data};
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push_ld) + AW'(push_alu);
        count_d = count_q + CW'(push_ld) + CW'(push_alu) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
        .entries_i(entries_q),
        .head_i   (head_q),
        .count_i  (count_q),
        .addr_i   (fwd_a1),
        .hit_o    (fwd_hit1),
        .data_o   (fwd_data1)
    );

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
        .entries_i(entries_q),
        .head_i   (head_q),
        .count_i  (count_q),
        .addr_i   (fwd_a2),
        .hit_o    (fwd_hit2),
        .data_o   (fwd_data2)
    );
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: scoreboard bench; a FIFO of accepted writes predicts drain order and forwarding.
module tb_rf_writeback_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   alu_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]             alu_rd = '0, ld_rd = '0, fwd_a1 = '0, fwd_a2 = '0;
    logic [XLEN-1:0]        alu_data = '0, ld_data = '0;
    logic                   in_ready, rf_we, fwd_hit1, fwd_hit2;
    logic [4:0]             rf_a3;
    logic [XLEN-1:0]        rf_wd, fwd_data1, fwd_data2;
    logic [$clog2(DEPTH):0] pending;

    rf_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .in_ready(in_ready), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .fwd_a1(fwd_a1), .fwd_a2(fwd_a2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Youngest queued write to a wins; x0 never hits.
    function automatic logic [XLEN:0] fwd_ref(input logic [4:0] a);
        fwd_ref = '0;
        if (a != 0)
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i].rd == a) fwd_ref = {1'b1, exp_q[i].data};
    endfunction

    always @(negedge clk) begin : monitor
        logic [XLEN:0] e1, e2;
        if (mon_en) begin
            e1 = fwd_ref(fwd_a1);
            e2 = fwd_ref(fwd_a2);
            chk("pending", 64'(pending), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready), 64'((DEPTH - exp_q.size()) >= 2));
            chk("rf_we", 64'(rf_we), 64'(exp_q.size() != 0));
            chk("fwd1", 64'({fwd_hit1, fwd_data1}), 64'(e1));
            chk("fwd2", 64'({fwd_hit2, fwd_data2}), 64'(e2));
            if (exp_q.size() != 0) begin
                chk("rf_a3", 64'(rf_a3), 64'(exp_q[0].rd));
                chk("rf_wd", 64'(rf_wd), 64'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                chk("rf_a3_idle", 64'(rf_a3), 64'd0);
                chk("rf_wd_idle", 64'(rf_wd), 64'd0);
            end
        end
    end

    // Drive one cycle; acceptance is decided from the model's occupancy, not the DUT.
    task automatic step(input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ldd,
                        input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                        input logic [4:0] f1, input logic [4:0] f2,
                        output logic acc_l, output logic acc_a);
        logic room;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        fwd_a1 = f1; fwd_a2 = f2;
        room  = (DEPTH - exp_q.size()) >= 2;
        acc_l = lv && room && lr != 0;
        acc_a = av && room && ar != 0;
        @(posedge clk);
        if (acc_l) exp_q.push_back('{lr, ldd});
        if (acc_a) exp_q.push_back('{ar, ad});
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] f1, input logic [4:0] f2);
        logic a, b;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, f1, f2, a, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic al, aa;
        logic [4:0] lr, ar;
        logic [XLEN-1:0] ldd, ad;
        int sent;
        #1 rst = 1'b1;
        #1;
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_hit1", 64'(fwd_hit1), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        step(0, 0, 0, 1, 5, 32'h0000_0005, 5, 0, al, aa);
        idle(2, 5, 0);

        step(1, 3, 32'hAAAA_0000, 1, 4, 32'h0000_1234, 3, 4, al, aa);
        idle(3, 3, 4);

        step(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, al, aa);
        idle(2, 0, 0);

        sent = 0;
        lr = 5'($urandom_range(1, 31)); ldd = $urandom;
        ar = 5'($urandom_range(1, 31)); ad = $urandom;
        for (int k = 0; k < 100 && sent < 20; k++) begin
            step(1, lr, ldd, 1, ar, ad, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), al, aa);
            if (al) begin sent++; lr = 5'($urandom_range(1, 31)); ldd = $urandom; end
            if (aa) begin sent++; ar = 5'($urandom_range(1, 31)); ad = $urandom; end
        end
        chk("dual_sent", 64'(sent >= 20), 64'd1);
        idle(5, 0, 0);

        step(1, 7, 32'h11, 1, 7, 32'h22, 7, 0, al, aa);
        idle(3, 7, 0);

        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), al, aa);
        idle(6, 0, 0);

        step(1, 1, 32'h101, 1, 2, 32'h202, 3, 2, al, aa);
        step(1, 3, 32'h303, 1, 4, 32'h404, 3, 2, al, aa);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        ld_valid = 1'b0;
        alu_valid = 1'b0;
        #1;
        chk("async_rst_rf_we", 64'(rf_we), 64'd0);
        chk("async_rst_rf_a3", 64'(rf_a3), 64'd0);
        chk("async_rst_rf_wd", 64'(rf_wd), 64'd0);
        chk("async_rst_pending", 64'(pending), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_hit1", 64'(fwd_hit1), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        idle(4, 3, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Write-side front end of the integer register file: collects register writes from the ALU and load paths, drops writes to x0, buffers them in order, and drains exactly one write per cycle into the register file's A3/WE/WD write port. Two forwarding lookup ports let decode see write data still pending in the queue, so RD1/RD2 consumers never read stale values. Sits between execute/memory and the register file in the single-cycle RISC-V datapath.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- XLEN, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU write request this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load write request this cycle
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load data
- in_ready  out  1  queue accepts up to two requests this cycle
- rf_we  out  1  register file write enable (to WE)
- rf_a3  out  5  register file write address (to A3)
- rf_wd  out  XLEN  register file write data (to WD)
- fwd_a1, fwd_a2  in  5  lookup addresses (same as decode's A1/A2)
- fwd_hit1, fwd_hit2  out  1  pending write exists for that address
- fwd_data1, fwd_data2  out  XLEN  data of youngest pending write
- pending  out  $clog2(DEPTH)+1  number of queued entries

## Operation
- Push: a request is accepted on a rising edge when valid && in_ready && rd != 0; rd == 0 requests are silently discarded (no entry, no error).
- Same-cycle ALU and load requests: load entry enqueued first (older), ALU entry second; both land on the same edge.
- in_ready = (DEPTH − count) ≥ 2, from registered count only; no combinational path from valid inputs. Requests with in_ready low are ignored; the upstream producer must hold them.
- Drain: when count > 0, head drives rf_we = 1, rf_a3 = head.rd, rf_wd = head.data; head pops on that edge. When empty, rf_we = 0, rf_a3 = 0, rf_wd = 0.
- Simultaneous push(es) and pop: count_next = count + pushes − pop; never exceeds DEPTH because in_ready guarantees two free slots.
- Pointers wrap modulo DEPTH; the full/empty decision uses count, not pointer comparison.
- Forwarding: for each lookup port, search all valid entries (head included) for rd == fwd_aN; return youngest match. fwd_aN == 0 → hit 0, data 0. No match → hit 0, data 0. Requests arriving in the current cycle are not forwarded.
- Write-after-write to the same rd: both entries are written in order; the final register file value equals the younger entry.

## Timing
- Reset (async assert): count = 0, pointers = 0, all entry valid bits cleared; rf_we = 0, rf_a3 = 0, rf_wd = 0, in_ready = 1, fwd_hit* = 0, pending = 0. Entries pending at reset are lost.
- Push latency: request accepted at edge N → rf_we high during cycle N+1 if the queue was empty → register file updated at edge N+1.
- Throughput: one register file write per cycle; sustained input above one write per cycle fills the queue and deasserts in_ready.
- rf_*, in_ready, pending: functions of registered state only. fwd_*: combinational from fwd_aN and state.

## Structure
- Shared package rv_pkg: XLEN, REG_ADDR_W = 5, wb_entry_t {valid, rd[4:0], data[XLEN-1:0]}.
- One sub-module: wb_fwd_lookup (entry array + head/count + address → hit/data, youngest-first priority), instantiated twice.

## Test plan
- Reset then single ALU write rd=5, data=0x0000_0005 → rf_we=1, rf_a3=5, rf_wd=0x5 exactly one cycle later; pending 1→0.
- Same cycle ld rd=3/0xAAAA_0000 and alu rd=4/0x1234 → rf writes rd=3 then rd=4 on consecutive cycles.
- alu rd=0, data=0xFFFF_FFFF → no entry, rf_we stays 0, pending stays 0.
- Dual pushes every cycle, DEPTH=4 → in_ready drops when pending ≥ 3; no drop or duplication; wrap-around order preserved over 20 writes.
- Queue holds rd=7/0x11 then rd=7/0x22; fwd_a1=7 → fwd_hit1=1, fwd_data1=0x22; fwd_a2=0 → hit 0.
- Assert rst mid-drain with 3 pending → outputs zero immediately (asynchronously); after release, pending=0, in_ready=1, no stale write.
